// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use / branch-operand stalls, branch/jump flush, mem freeze with watchdog.
// Optional perf counters built only when HAZ_PERF_CNT_EN is defined; otherwise the counter ports read 0.
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_dest_reg,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_dest_reg,
    input  logic             mem_busy,
    output logic             Data_Hazard,
    output logic             Control_Hazard,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_flush,
    output logic             pipe_freeze,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // state  | meaning
    // RUN    | normal issue; single-cycle stalls and flushes decided combinationally
    // STALL  | extra bubble(s) for a branch waiting on a load in EX
    // FREEZE | data memory busy, whole pipe held; watchdog counting down
    typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

    localparam logic [CNT_W-1:0] WD_LOAD = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [1:0]       stall_left_q, stall_left_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             ret_stall_q, ret_stall_d;
    logic             timeout_q, timeout_d;
    logic             busy_ign_q, busy_ign_d;

    logic ex_hit, mem_hit, lu, ba, bl, bm, any_haz, busy_eff;
    logic data_haz, pc_we, ifid_we, flush, freeze;

    function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
        return (dest != 5'd0) && (dest == src);
    endfunction

    always_comb begin
        ex_hit   = reg_match(id_ex_dest_reg, if_id_rs) | reg_match(id_ex_dest_reg, if_id_rt);
        mem_hit  = reg_match(ex_mem_dest_reg, if_id_rs) | reg_match(ex_mem_dest_reg, if_id_rt);
        lu       = id_ex_mem_read & ex_hit;
        ba       = id_is_branch & id_ex_reg_write & ~id_ex_mem_read & ex_hit;
        bl       = id_is_branch & id_ex_mem_read & ex_hit;
        bm       = id_is_branch & ex_mem_mem_read & mem_hit;
        any_haz  = lu | ba | bl | bm;
        // After a watchdog release a stuck mem_busy is masked until it drops once.
        busy_eff = mem_busy & ~busy_ign_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            stall_left_q <= 2'd0;
            wd_q         <= '0;
            ret_stall_q  <= 1'b0;
            timeout_q    <= 1'b0;
            busy_ign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            wd_q         <= wd_d;
            ret_stall_q  <= ret_stall_d;
            timeout_q    <= timeout_d;
            busy_ign_q   <= busy_ign_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        wd_d         = wd_q;
        ret_stall_d  = ret_stall_q;
        timeout_d    = timeout_q;
        busy_ign_d   = busy_ign_q & mem_busy;
        data_haz     = 1'b1;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        flush        = 1'b0;
        freeze       = 1'b0;

        case (state_q)
            RUN: begin
                if (busy_eff) begin
                    state_d     = FREEZE;
                    ret_stall_d = 1'b0;
                    wd_d        = WD_LOAD;
                end else if (any_haz) begin
                    data_haz = 1'b0;
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    if (bl) begin
                        state_d      = STALL;
                        stall_left_d = 2'd1;
                    end
                end else if (branch_taken | jump) begin
                    flush = 1'b1;
                end
            end
            STALL: begin
                data_haz = 1'b0;
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                if (busy_eff) begin
                    state_d     = FREEZE;
                    ret_stall_d = 1'b1;
                    wd_d        = WD_LOAD;
                end else begin
                    stall_left_d = stall_left_q - 2'd1;
                    if (stall_left_q <= 2'd1) state_d = RUN;
                end
            end
            FREEZE: begin
                freeze  = 1'b1;
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                if (!mem_busy) begin
                    state_d = ret_stall_q ? STALL : RUN;
                end else if (wd_q == '0) begin
                    // Watchdog terminal count: release after MEM_TIMEOUT frozen cycles.
                    timeout_d  = 1'b1;
                    busy_ign_d = 1'b1;
                    state_d    = ret_stall_q ? STALL : RUN;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign Data_Hazard    = data_haz;
    assign Control_Hazard = timeout_q;
    assign pc_write       = pc_we;
    assign if_id_write    = ifid_we;
    assign if_flush       = flush;
    assign pipe_freeze    = freeze;
    assign timeout_err    = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((!data_haz || freeze) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (flush_cnt_q != '1))                 flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (MEM_TIMEOUT=4); counter expectations follow HAZ_PERF_CNT_EN.
module tb_hazard_sequencer;
    localparam int CNT_W = 16;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [4:0]       if_id_rs, if_id_rt, id_ex_dest_reg, ex_mem_dest_reg;
    logic             id_is_branch, branch_taken, jump, id_ex_reg_write, id_ex_mem_read;
    logic             ex_mem_mem_read, mem_busy;
    logic             Data_Hazard, Control_Hazard, pc_write, if_id_write, if_flush;
    logic             pipe_freeze, timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_chk = 0;
    int n_err = 0;

    hazard_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken), .jump(jump),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_dest_reg(id_ex_dest_reg),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_dest_reg(ex_mem_dest_reg),
        .mem_busy(mem_busy),
        .Data_Hazard(Data_Hazard), .Control_Hazard(Control_Hazard),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
        .pipe_freeze(pipe_freeze), .timeout_err(timeout_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pc(input int v);
        return PERF_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic clr();
        if_id_rs = 0; if_id_rt = 0; id_ex_dest_reg = 0; ex_mem_dest_reg = 0;
        id_is_branch = 0; branch_taken = 0; jump = 0; id_ex_reg_write = 0;
        id_ex_mem_read = 0; ex_mem_mem_read = 0; mem_busy = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        nxt(); nxt();
        reset = 1'b0;
    endtask

    task automatic chk_run(input string tag);
        chk({tag, ".dh"}, Data_Hazard, 1);
        chk({tag, ".pcw"}, pc_write, 1);
        chk({tag, ".frz"}, pipe_freeze, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clr();
        reset = 1'b1;
        smp();
        chk("rst.dh", Data_Hazard, 1);
        chk("rst.ch", Control_Hazard, 0);
        chk("rst.pcw", pc_write, 1);
        chk("rst.ifidw", if_id_write, 1);
        chk("rst.flush", if_flush, 0);
        chk("rst.frz", pipe_freeze, 0);
        chk("rst.to", timeout_err, 0);
        chk("rst.sc", stall_cycles, 0);
        chk("rst.fc", flush_count, 0);
        nxt();
        reset = 1'b0;

        // load-use on rs
        do_reset();
        id_ex_mem_read = 1; id_ex_dest_reg = 5; if_id_rs = 5;
        smp();
        chk("lu.dh", Data_Hazard, 0);
        chk("lu.pcw", pc_write, 0);
        chk("lu.ifidw", if_id_write, 0);
        nxt(); clr();
        smp();
        chk_run("lu.after");
        chk("lu.sc", stall_cycles, pc(1));
        nxt();

        // branch on ALU result in EX: one stall, back in RUN
        id_is_branch = 1; if_id_rs = 9; id_ex_reg_write = 1; id_ex_dest_reg = 9;
        smp();
        chk("ba.dh", Data_Hazard, 0);
        nxt(); clr();
        smp();
        chk("ba.after.dh", Data_Hazard, 1);
        nxt();

        // branch on load in MEM: one stall
        id_is_branch = 1; if_id_rt = 3; ex_mem_mem_read = 1; ex_mem_dest_reg = 3;
        smp();
        chk("bm.dh", Data_Hazard, 0);
        nxt(); clr();

        // branch on load in EX: two stalls, flush suppressed, then one flush
        do_reset();
        id_is_branch = 1; if_id_rt = 7; id_ex_mem_read = 1; id_ex_reg_write = 1;
        id_ex_dest_reg = 7; branch_taken = 1;
        smp();
        chk("bl.c0.dh", Data_Hazard, 0);
        chk("bl.c0.flush", if_flush, 0);
        nxt(); clr();
        id_is_branch = 1; if_id_rt = 7; branch_taken = 1;
        smp();
        chk("bl.c1.dh", Data_Hazard, 0);
        chk("bl.c1.pcw", pc_write, 0);
        chk("bl.c1.flush", if_flush, 0);
        nxt();
        smp();
        chk("bl.c2.dh", Data_Hazard, 1);
        chk("bl.c2.flush", if_flush, 1);
        chk("bl.c2.ch", Control_Hazard, 0);
        nxt(); clr();
        smp();
        chk("bl.c3.flush", if_flush, 0);
        chk("bl.fc", flush_count, pc(1));
        chk("bl.sc", stall_cycles, pc(2));
        nxt();

        // r0 never matches; jump flushes
        do_reset();
        id_ex_mem_read = 1; id_ex_dest_reg = 0; if_id_rs = 0; jump = 1;
        smp();
        chk("r0.dh", Data_Hazard, 1);
        chk("r0.flush", if_flush, 1);
        nxt(); clr();
        smp();
        chk("r0.flush2", if_flush, 0);
        chk("r0.fc", flush_count, pc(1));
        chk("r0.sc", stall_cycles, pc(0));
        nxt();

        // freeze during STALL, stall resumes afterwards
        do_reset();
        id_is_branch = 1; if_id_rs = 4; id_ex_mem_read = 1; id_ex_dest_reg = 4;
        smp();
        chk("fs.a.dh", Data_Hazard, 0);
        nxt(); clr();
        mem_busy = 1;
        smp();
        chk("fs.b.dh", Data_Hazard, 0);
        chk("fs.b.frz", pipe_freeze, 0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_busy = 0;
            smp();
            chk($sformatf("fs.f%0d.frz", i), pipe_freeze, 1);
            chk($sformatf("fs.f%0d.dh", i), Data_Hazard, 1);
            chk($sformatf("fs.f%0d.pcw", i), pc_write, 0);
            chk($sformatf("fs.f%0d.ifidw", i), if_id_write, 0);
            nxt();
        end
        smp();
        chk("fs.resume.dh", Data_Hazard, 0);
        chk("fs.resume.frz", pipe_freeze, 0);
        nxt();
        smp();
        chk_run("fs.end");
        chk("fs.sc", stall_cycles, pc(6));
        nxt();

        // watchdog: mem_busy stuck high, release after 4 frozen cycles
        do_reset();
        mem_busy = 1;
        smp();
        chk("wd.entry.frz", pipe_freeze, 0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("wd.f%0d.frz", i), pipe_freeze, 1);
            chk($sformatf("wd.f%0d.to", i), timeout_err, 0);
            nxt();
        end
        smp();
        chk("wd.rel.frz", pipe_freeze, 0);
        chk("wd.rel.to", timeout_err, 1);
        chk("wd.rel.ch", Control_Hazard, 1);
        chk("wd.rel.pcw", pc_write, 1);
        nxt();
        smp();
        chk("wd.ign.frz", pipe_freeze, 0);
        nxt();
        mem_busy = 0;
        smp();
        chk("wd.drop.frz", pipe_freeze, 0);
        nxt();
        mem_busy = 1;
        nxt();
        smp();
        chk("wd.refrz.frz", pipe_freeze, 1);
        chk("wd.refrz.ch", Control_Hazard, 1);
        #1 reset = 1'b1;
        #1;
        chk("wd.rst.frz", pipe_freeze, 0);
        chk("wd.rst.to", timeout_err, 0);
        chk("wd.rst.ch", Control_Hazard, 0);
        chk("wd.rst.pcw", pc_write, 1);
        chk("wd.rst.ifidw", if_id_write, 1);
        chk("wd.rst.dh", Data_Hazard, 1);
        chk("wd.rst.sc", stall_cycles, 0);
        nxt();
        clr();
        reset = 1'b0;
        nxt();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
